// File: rtl/e_mdu_pkg.sv
// Shared constants for the E-stage multiply/divide unit: MDU opcodes and FSM states.
// Compile with +define+MDU_DIV_EN to build the divider; it is left undefined by default.
package e_mdu_pkg;

  localparam int unsigned MDU_OP_W = 4;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_none  = 4'd0,
    MDU_mult  = 4'd1,
    MDU_multu = 4'd2,
    MDU_div   = 4'd3,
    MDU_divu  = 4'd4,
    MDU_mthi  = 4'd5,
    MDU_mtlo  = 4'd6,
    MDU_mfhi  = 4'd7,
    MDU_mflo  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_mult_op(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_mult) || (op == MDU_multu);
  endfunction

  function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
    return (op == MDU_div) || (op == MDU_divu);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational MDU arithmetic: {hi, lo} for mult/multu and, with MDU_DIV_EN, div/divu.
// Divide-by-zero and signed-overflow results are fixed here rather than left to the operator.
module e_mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [MDU_OP_W-1:0] op,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  output logic [63:0]         res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

`ifdef MDU_DIV_EN
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic        div_zero_s;
  logic        div_ovf_s;

  assign quo_s      = $signed(a) / $signed(b);
  assign rem_s      = $signed(a) % $signed(b);
  assign quo_u      = a / b;
  assign rem_u      = a % b;
  assign div_zero_s = (b == 32'd0);
  assign div_ovf_s  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`endif

  // Select the {hi, lo} result for the requested operation.
  always_comb begin
    res = 64'd0;
    case (op)
      MDU_mult:  res = prod_s;
      MDU_multu: res = prod_u;
`ifdef MDU_DIV_EN
      MDU_div: begin
        if (div_zero_s) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (div_ovf_s) begin
          res = {32'd0, 32'h8000_0000};
        end else begin
          res = {rem_s, quo_s};
        end
      end
      MDU_divu: begin
        if (div_zero_s) begin
          res = {a, 32'hFFFF_FFFF};
        end else begin
          res = {rem_u, quo_u};
        end
      end
`endif
      default: res = 64'd0;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multi-cycle multiply/divide unit owning HI/LO; busy covers the fixed operation latency.
// The optional divider is enabled by the MDU_DIV_EN macro.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] MDUOp,
  input  logic [31:0]         A,
  input  logic [31:0]         B,
  output logic                busy,
  output logic [31:0]         HI,
  output logic [31:0]         LO,
  output logic [31:0]         MDUout
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [3:0]  cnt;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  mdu_state_e  state_s;
  logic [3:0]  cnt_next_s;
  logic [31:0] res_hi_next_s;
  logic [31:0] res_lo_next_s;
  logic [31:0] hi_next_s;
  logic [31:0] lo_next_s;
  logic [63:0] calc_s;
  logic        launch_s;

  e_mdu_calc u_calc (
    .op  (MDUOp),
    .a   (A),
    .b   (B),
    .res (calc_s)
  );

`ifdef MDU_DIV_EN
  assign launch_s = start && (is_mult_op(MDUOp) || is_div_op(MDUOp));
`else
  assign launch_s = start && is_mult_op(MDUOp);
`endif

  assign state_s = (cnt == 4'd0) ? ST_IDLE : ST_RUN;
  assign busy    = (state_s == ST_RUN);

  // State, result latch and architectural HI/LO registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= 4'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      HI     <= 32'd0;
      LO     <= 32'd0;
    end else begin
      cnt    <= cnt_next_s;
      res_hi <= res_hi_next_s;
      res_lo <= res_lo_next_s;
      HI     <= hi_next_s;
      LO     <= lo_next_s;
    end
  end

  // Next-state: launch or mthi/mtlo in IDLE; count down and commit in RUN.
  always_comb begin
    cnt_next_s    = cnt;
    res_hi_next_s = res_hi;
    res_lo_next_s = res_lo;
    hi_next_s     = HI;
    lo_next_s     = LO;
    case (state_s)
      ST_IDLE: begin
        if (launch_s) begin
          res_hi_next_s = calc_s[63:32];
          res_lo_next_s = calc_s[31:0];
          cnt_next_s    = is_mult_op(MDUOp) ? MULT_N : DIV_N;
        end else if (MDUOp == MDU_mthi) begin
          hi_next_s = A;
        end else if (MDUOp == MDU_mtlo) begin
          lo_next_s = A;
        end else begin
          cnt_next_s = 4'd0;
        end
      end
      ST_RUN: begin
        // Anything arriving while busy is dropped; only the countdown advances.
        if (cnt == 4'd1) begin
          hi_next_s  = res_hi;
          lo_next_s  = res_lo;
          cnt_next_s = 4'd0;
        end else begin
          cnt_next_s = cnt - 4'd1;
        end
      end
      default: cnt_next_s = 4'd0;
    endcase
  end

  // Read port shows committed HI/LO only, never the in-flight result.
  always_comb begin
    MDUout = 32'd0;
    case (MDUOp)
      MDU_mfhi: MDUout = HI;
      MDU_mflo: MDUout = LO;
      default:  MDUout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu: latency, arithmetic, ignored ops, moves and reset abort.
module tb_e_mdu;
  import e_mdu_pkg::*;

  localparam int unsigned N_MUL = 5;
  localparam int unsigned N_DIV = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mdu_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] cur_hi;
  logic [31:0] cur_lo;

  e_mdu #(.MULT_CYCLES(N_MUL), .DIV_CYCLES(N_DIV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .MDUOp   (mdu_op),
    .A       (a),
    .B       (b),
    .busy    (busy),
    .HI      (hi),
    .LO      (lo),
    .MDUout  (mdu_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, scramble operands, check busy each cycle, hold of HI/LO, then commit.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] ia,
                        input logic [31:0] ib, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    mdu_op = op; a = ia; b = ib; start = 1'b1;
    step();
    start = 1'b0; mdu_op = MDU_none; a = 32'h5A5A_5A5A; b = 32'h0000_0003;
    for (int i = 1; i <= n; i++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (i == n) begin
        check({tag, "_hi_hold"}, hi, cur_hi);
        check({tag, "_lo_hold"}, lo, cur_lo);
      end
      step();
    end
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    cur_hi = exp_hi;
    cur_lo = exp_lo;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; mdu_op = MDU_none; a = 32'd0; b = 32'd0;
    cur_hi = 32'd0; cur_lo = 32'd0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_out", mdu_out, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    run_op("mult_neg", MDU_mult, 32'hFFFF_FFFF, 32'd2, N_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu", MDU_multu, 32'hFFFF_FFFF, 32'd2, N_MUL, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_nn", MDU_mult, 32'hFFFF_FFFD, 32'hFFFF_FFFB, N_MUL, 32'd0, 32'd15);
    run_op("mult_min", MDU_mult, 32'h8000_0000, 32'h8000_0000, N_MUL, 32'h4000_0000, 32'd0);
    run_op("multu_max", MDU_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, N_MUL, 32'hFFFF_FFFE, 32'h0000_0001);

    // divu start and mthi while busy must both be dropped
    mdu_op = MDU_mult; a = 32'd3; b = 32'd4; start = 1'b1;
    step();
    for (int i = 1; i <= int'(N_MUL); i++) begin
      check("ign_busy", {31'd0, busy}, 32'd1);
      start = 1'b0; mdu_op = MDU_none; a = 32'd0; b = 32'd0;
      if (i == 1) begin
        start = 1'b1; mdu_op = MDU_divu; a = 32'd100; b = 32'd3;
      end else if (i == 2) begin
        mdu_op = MDU_mthi; a = 32'h0000_1234;
      end else begin
        mdu_op = MDU_none;
      end
      step();
    end
    start = 1'b0; mdu_op = MDU_none;
    check("ign_idle", {31'd0, busy}, 32'd0);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd12);
    step();
    check("ign_stay_idle", {31'd0, busy}, 32'd0);

    mdu_op = MDU_mthi; a = 32'h0000_BEEF;
    step();
    mdu_op = MDU_mtlo; a = 32'h0000_CAFE;
    step();
    mdu_op = MDU_none; a = 32'd0;
    check("mthi_hi", hi, 32'h0000_BEEF);
    check("mtlo_lo", lo, 32'h0000_CAFE);
    mdu_op = MDU_mflo; #1;
    check("mflo_out", mdu_out, 32'h0000_CAFE);
    mdu_op = MDU_mfhi; #1;
    check("mfhi_out", mdu_out, 32'h0000_BEEF);
    mdu_op = MDU_none; #1;
    check("none_out", mdu_out, 32'd0);
    cur_hi = 32'h0000_BEEF;
    cur_lo = 32'h0000_CAFE;

`ifdef MDU_DIV_EN
    run_op("div_neg", MDU_div, 32'hFFFF_FFF9, 32'd2, N_DIV, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb", MDU_div, 32'd7, 32'hFFFF_FFFE, N_DIV, 32'd1, 32'hFFFF_FFFD);
    run_op("divu_z", MDU_divu, 32'd7, 32'd0, N_DIV, 32'd7, 32'hFFFF_FFFF);
    run_op("div_z", MDU_div, 32'hFFFF_FFFB, 32'd0, N_DIV, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("div_ovf", MDU_div, 32'h8000_0000, 32'hFFFF_FFFF, N_DIV, 32'd0, 32'h8000_0000);
    run_op("divu", MDU_divu, 32'hFFFF_FFFF, 32'd16, N_DIV, 32'h0000_000F, 32'h0FFF_FFFF);
`else
    mdu_op = MDU_div; a = 32'd9; b = 32'd2; start = 1'b1;
    step();
    start = 1'b0; mdu_op = MDU_none;
    check("nodiv_busy", {31'd0, busy}, 32'd0);
    step();
    step();
    check("nodiv_busy2", {31'd0, busy}, 32'd0);
    check("nodiv_hi", hi, 32'h0000_BEEF);
    check("nodiv_lo", lo, 32'h0000_CAFE);
`endif

    // reset asserted mid-run aborts immediately and suppresses the commit
    mdu_op = MDU_mult; a = 32'd5; b = 32'd5; start = 1'b1;
    step();
    start = 1'b0; mdu_op = MDU_none;
    step();
    step();
    check("abort_pre_busy", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (N_MUL + 3) step();
    check("post_busy", {31'd0, busy}, 32'd0);
    check("post_hi", hi, 32'd0);
    check("post_lo", lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
